ofmap_quant_pack: RTL
=====================

OFMAP_QUANT_PACK -- requirements
Module: ofmap_quant_pack

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter DWIDTH, default 32, SHALL be the width of incoming partial-sum results.
REQ-003 Parameter QWIDTH, default 8, SHALL be the width of one quantised activation.
REQ-004 Parameter LANES, default 4, SHALL be the number of activations per output word.
REQ-005 Parameter FAWIDTH, default 2, SHALL be the output FIFO address width (depth 2^FAWIDTH words).
REQ-006 clk  in  1  SHALL be the rising-edge clock.
REQ-007 rst  in  1  SHALL be the asynchronous active-high reset.
REQ-008 in_valid  in  1  SHALL qualify in_data; it has no backpressure and is accepted every cycle it is high.
REQ-009 in_data  in  DWIDTH  SHALL be the signed accumulated sum from the upstream psum stage.
REQ-010 flush  in  1  SHALL be a one-cycle pulse marking the end of an output channel.
REQ-011 cfg_bias  in  DWIDTH  SHALL be the signed bias; cfg_shift  in  5  SHALL be the requantisation right-shift; cfg_relu  in  1  SHALL enable ReLU; all cfg_* inputs SHALL be held stable while busy=1.
REQ-012 out_valid  out  1, out_ready  in  1, out_data  out  LANES*QWIDTH, out_strb  out  LANES SHALL form a valid/ready output stream.
REQ-013 busy  out  1  SHALL be high while any pipeline stage, the lane packer or the FIFO holds data.
REQ-014 err_ovf  out  1  SHALL be a sticky flag set when a word is dropped due to a full FIFO.

Function
REQ-015 Stage 1 SHALL register in_data + cfg_bias as a signed DWIDTH+1-bit sum with its valid and flush bits.
REQ-016 Stage 2 SHALL apply ReLU (negative -> 0) when cfg_relu=1.
REQ-017 Stage 2 SHALL then compute (x + 2^(cfg_shift-1)) >>> cfg_shift (no rounding term when cfg_shift=0) in DWIDTH+2 bits, without intermediate overflow.
REQ-018 Stage 2 SHALL saturate the result to signed QWIDTH: [-128, 127] for QWIDTH=8.
REQ-019 Stage 3 SHALL place activations into lanes via a lane counter 0..LANES-1, with lane 0 at out_data[QWIDTH-1:0].
REQ-020 When lane LANES-1 is filled, the word SHALL be pushed into the FIFO with out_strb all-ones and the counter SHALL wrap to 0.
REQ-021 Latency: for the LANES-th element sampled on edge k, out_valid SHALL be high after edge k+3 when the FIFO was previously empty.
REQ-022 Flush SHALL travel with the pipeline; it applies after all elements sampled on or before its edge, including an element sampled on the same edge.
REQ-023 On flush with lane count n>0, the partial word SHALL be pushed with unfilled lanes zero and out_strb bit i=1 only for i<n; the counter SHALL reset to 0.
REQ-024 On flush with lane count 0, no word SHALL be pushed.
REQ-025 A word SHALL be transferred on each cycle where out_valid and out_ready are both high; out_data and out_strb SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 A push while the FIFO is full and not simultaneously popped SHALL drop the new word and set err_ovf; a simultaneous push and pop at full SHALL succeed.
REQ-027 busy SHALL be the OR of the stage-1/2 valid bits, lane count != 0, and FIFO non-empty.

Reset
REQ-028 Reset SHALL clear all pipeline valid bits, the lane counter, FIFO pointers and err_ovf, with out_valid=0, busy=0, out_data=0 and out_strb=0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight and partially packed data; no partial word SHALL emerge after reset.

Structure
REQ-030 The shared package ru_ofmap_pkg SHALL hold the DWIDTH, QWIDTH and LANES defaults, the saturation bounds QMAX/QMIN, and the lane-counter width.
REQ-031 The output buffer SHALL be one instance of the existing syncfifo (DWIDTH=LANES*(QWIDTH+1) carrying data and strobe, AWIDTH=FAWIDTH); no other sub-module is used.

Verification
REQ-032 cfg_shift=4, bias=0, relu=0; inputs 40, -40, 5000, -5000 then out_ready=1 -> one word 0x807FFE03 with strb 0xF.
REQ-033 Same inputs with relu=1 -> word 0x007F0003.
REQ-034 cfg_shift=0, bias=1; input 0x7FFFFFFF x4 -> word 0x7F7F7F7F (no wrap through bias add).
REQ-035 Inputs 16, 32 (shift=4) with flush on the same edge as 32 -> word 0x00000201 with strb 0x3; a second flush yields no word.
REQ-036 out_ready=0; feed 20 elements -> 4 words stored, err_ovf=1; then out_ready=1 -> exactly 4 words in order and busy falls to 0.
REQ-037 Feed 2 elements, pulse rst -> out_valid=0, busy=0; then feed 4 new elements -> exactly one word containing only the new data.

Source files
------------

// File: rtl/ru_ofmap_pkg.sv
// Shared constants for the output-feature-map quantise/pack block.
// Default widths, saturation bounds for the default activation width,
// and the lane-counter width used by the packer.
package ru_ofmap_pkg;

   localparam int DWIDTH_D = 32;
   localparam int QWIDTH_D = 8;
   localparam int LANES_D  = 4;

   localparam int QMAX = (1 << (QWIDTH_D - 1)) - 1;
   localparam int QMIN = -(1 << (QWIDTH_D - 1));

   localparam int LCW = $clog2(LANES_D);

endpackage

// File: rtl/ofmap_quant_pack_if.sv
// Stream bundle for ofmap_quant_pack.
// Input side: in_valid/in_data/flush (no backpressure).
// Output side: out_valid/out_ready/out_data/out_strb (valid/ready).
// master = producer of inputs / consumer of words (testbench side),
// slave  = the quantise/pack block.
interface ofmap_quant_pack_if
   import ru_ofmap_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_D,
   parameter int QWIDTH = QWIDTH_D,
   parameter int LANES  = LANES_D
) ();

   logic                      in_valid;
   logic [DWIDTH-1:0]         in_data;
   logic                      flush;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*QWIDTH-1:0]   out_data;
   logic [LANES-1:0]          out_strb;

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  out_valid, out_data, out_strb
   );

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output out_valid, out_data, out_strb
   );

endinterface

// File: rtl/syncfifo.sv
// Synchronous FIFO, depth 2^AWIDTH, combinational read of the head entry.
// Ports: wr_en_i/wr_data_i/full_o (write), rd_en_i/rd_data_o/empty_o (read).
// A write while full is accepted only when a read happens on the same cycle.
module syncfifo #(
   parameter int DWIDTH = 36,
   parameter int AWIDTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   output logic              full_o,
   input  logic              rd_en_i,
   output logic [DWIDTH-1:0] rd_data_o,
   output logic              empty_o
);

   localparam int DEPTH = 1 << AWIDTH;

   logic [AWIDTH-1:0] wptr_q;
   logic [AWIDTH-1:0] rptr_q;
   logic [AWIDTH:0]   cnt_q;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic              wr_ok;
   logic              rd_ok;

   assign full_o    = (cnt_q == (AWIDTH+1)'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign rd_ok     = rd_en_i && !empty_o;
   assign wr_ok     = wr_en_i && (!full_o || rd_ok);
   assign rd_data_o = mem_q[rptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) wptr_q <= wptr_q + 1'b1;
         if (rd_ok) rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + (AWIDTH+1)'(wr_ok) - (AWIDTH+1)'(rd_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/ofmap_quant_pack.sv
// Requantises psum results (bias, ReLU, rounding shift, saturate) and packs
// LANES activations per word into an output FIFO.
// Ports: clk, rst (async high); s_if (stream bundle, slave side);
// cfg_bias_i/cfg_shift_i/cfg_relu_i (static while busy); busy_o; err_ovf_o.
module ofmap_quant_pack
   import ru_ofmap_pkg::*;
#(
   parameter int DWIDTH  = DWIDTH_D,
   parameter int QWIDTH  = QWIDTH_D,
   parameter int LANES   = LANES_D,
   parameter int FAWIDTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   ofmap_quant_pack_if.slave s_if,
   input  logic [DWIDTH-1:0] cfg_bias_i,
   input  logic [4:0]        cfg_shift_i,
   input  logic              cfg_relu_i,
   output logic              busy_o,
   output logic              err_ovf_o
);

   localparam int XW = DWIDTH + 2;
   localparam int WW = LANES * QWIDTH;
   localparam int FW = LANES * (QWIDTH + 1);
   localparam int LW = (LANES == LANES_D) ? LCW : $clog2(LANES);
   localparam int HI = (QWIDTH == QWIDTH_D) ? QMAX
                                            : (1 << (QWIDTH - 1)) - 1;
   localparam int LO = (QWIDTH == QWIDTH_D) ? QMIN
                                            : -(1 << (QWIDTH - 1));
   localparam logic signed [XW-1:0] HI_S = XW'(HI);
   localparam logic signed [XW-1:0] LO_S = XW'(LO);

   // stage 1: bias add
   logic              s1_valid_q;
   logic              s1_flush_q;
   logic [DWIDTH:0]   s1_sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_flush_q <= 1'b0;
         s1_sum_q   <= '0;
      end else begin
         s1_valid_q <= s_if.in_valid;
         s1_flush_q <= s_if.flush;
         if (s_if.in_valid)
            s1_sum_q <= {s_if.in_data[DWIDTH-1], s_if.in_data}
                      + {cfg_bias_i[DWIDTH-1], cfg_bias_i};
      end
   end

   // stage 2: relu, rounding shift, saturate
   logic signed [XW-1:0] x_d;
   logic signed [XW-1:0] rnd_d;
   logic signed [XW-1:0] r_d;
   logic [QWIDTH-1:0]    q_d;

   always_comb begin
      x_d = {s1_sum_q[DWIDTH], s1_sum_q};
      if (cfg_relu_i && x_d[XW-1]) x_d = '0;
      // (1 << shift) >> 1 gives 2^(shift-1), and 0 when shift is 0
      rnd_d = (XW'(1) << cfg_shift_i) >> 1;
      r_d   = (x_d + rnd_d) >>> cfg_shift_i;
      if (r_d > HI_S)      q_d = HI_S[QWIDTH-1:0];
      else if (r_d < LO_S) q_d = LO_S[QWIDTH-1:0];
      else                 q_d = r_d[QWIDTH-1:0];
   end

   logic              s2_valid_q;
   logic              s2_flush_q;
   logic [QWIDTH-1:0] s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_flush_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         s2_flush_q <= s1_flush_q;
         if (s1_valid_q) s2_q <= q_d;
      end
   end

   // stage 3: lane packer
   logic [LW-1:0]    lane_q;
   logic [WW-1:0]    word_q;
   logic             push_q;
   logic [FW-1:0]    push_word_q;
   logic [WW-1:0]    word_d;
   logic [LW:0]      fill_d;
   logic [LANES-1:0] strb_d;
   logic             push_d;

   always_comb begin
      word_d = word_q;
      if (s2_valid_q)
         word_d[int'(lane_q)*QWIDTH +: QWIDTH] = s2_q;
      // lanes occupied once this cycle's element (if any) is placed
      fill_d = {1'b0, lane_q} + (LW+1)'(s2_valid_q);
      strb_d = '0;
      for (int i = 0; i < LANES; i++)
         strb_d[i] = ((LW+1)'(i) < fill_d);
      push_d = (s2_valid_q && (lane_q == LW'(LANES - 1)))
            || (s2_flush_q && (fill_d != '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q      <= '0;
         word_q      <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
      end else begin
         push_q <= push_d;
         if (push_d) begin
            push_word_q <= {strb_d, word_d};
            word_q      <= '0;
            lane_q      <= '0;
         end else begin
            word_q <= word_d;
            if (s2_valid_q) lane_q <= lane_q + 1'b1;
         end
      end
   end

   // output buffer
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic [FW-1:0] fifo_rd;
   logic          err_ovf_q;

   assign pop = s_if.out_ready && !fifo_empty;

   syncfifo #(
      .DWIDTH (FW),
      .AWIDTH (FAWIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push_q),
      .wr_data_i (push_word_q),
      .full_o    (fifo_full),
      .rd_en_i   (pop),
      .rd_data_o (fifo_rd),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
      end else if (push_q && fifo_full && !pop) begin
         err_ovf_q <= 1'b1;
      end
   end

   // FIFO storage is not reset, so mask the head entry while empty
   assign s_if.out_valid = !fifo_empty;
   assign s_if.out_data  = fifo_empty ? '0 : fifo_rd[WW-1:0];
   assign s_if.out_strb  = fifo_empty ? '0 : fifo_rd[FW-1 -: LANES];

   assign err_ovf_o = err_ovf_q;
   // push_q counts as packer-held data between the lane wrap and the write
   assign busy_o = s1_valid_q || s2_valid_q || (lane_q != '0)
                || push_q || !fifo_empty;

endmodule
